// File: rtl/pmod_pkg.sv
// rtl/pmod_pkg.sv - shared types and frame constants for the PMOD ADC reader
//
// Holds the reader FSM state encoding and the serial frame geometry:
// a 16-bit frame of 4 leading zeros followed by a 12-bit unsigned result.

package pmod_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;
    localparam int ADC_W      = 12;

endpackage

// File: rtl/sclk_divider.sv
// rtl/sclk_divider.sv - SCLK half-period counter with end-of-half strobe
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   run      : count while high; counter held at 0 while low
//   half_end : strobe on the last clk cycle of each CLK_DIV-cycle half period

module sclk_divider
    import pmod_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic half_end
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign half_end = run && (cnt_q == LAST);

endmodule

// File: rtl/pmod_ad_reader.sv
// rtl/pmod_ad_reader.sv - periodic serial ADC reader with valid/ready output
//
// Ports:
//   clk, rst         : clock (rising edge) and synchronous active-high reset
//   en               : enables periodic conversions
//   clr              : clears the sticky overrun / frame_err flags
//   miso             : serial data from the ADC, MSB first
//   cs_n, sclk       : ADC chip select (active low) and serial clock (idle high)
//   sample           : last converted 12-bit value
//   sample_valid     : sample holds an unconsumed value
//   sample_ready     : consumer accepts sample when high with sample_valid
//   overrun          : sticky, a new sample replaced an unconsumed one
//   frame_err        : sticky, a frame had nonzero leading bits
//   busy             : a frame is in progress

module pmod_ad_reader
    import pmod_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             miso,
    output logic             cs_n,
    output logic             sclk,
    output logic [ADC_W-1:0] sample,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun,
    output logic             frame_err,
    output logic             busy
);

    localparam int BIT_W                = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
    localparam logic [15:0] PER_LAST      = 16'(SAMPLE_PERIOD - 1);

    state_e                state_q;
    logic                  cs_n_q;
    logic                  sclk_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [BIT_W-1:0]      bit_q;
    logic [15:0]           per_q;
    logic [15:0]           per_d;
    logic [ADC_W-1:0]      sample_q;
    logic                  valid_q;
    logic                  overrun_q;
    logic                  frame_err_q;

    logic half_end;
    logic div_run;
    logic start;
    logic publish;
    logic handshake;
    logic lead_nonzero;

    // Free-running period counter; it keeps counting through a frame so
    // successive cs_n falling edges stay exactly SAMPLE_PERIOD apart.
    always_comb begin
        per_d = per_q;
        if (!en || per_q == PER_LAST) begin
            per_d = '0;
        end else begin
            per_d = per_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            per_q <= '0;
        end else begin
            per_q <= per_d;
        end
    end

    assign div_run      = (state_q == SETUP) || (state_q == SHIFT);
    assign start        = en && (per_q == PER_LAST);
    assign publish      = (state_q == DONE);
    assign handshake    = valid_q && sample_ready;
    assign lead_nonzero = |shift_q[FRAME_BITS-1 -: LEAD_ZEROS];

    sclk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .run      (div_run),
        .half_end (half_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            shift_q     <= '0;
            bit_q       <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SETUP;
                        cs_n_q  <= 1'b0;
                    end
                end
                SETUP: begin
                    if (half_end) begin
                        state_q <= SHIFT;
                        sclk_q  <= 1'b0;
                        bit_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        if (!sclk_q) begin
                            // Rising SCLK edge: capture the bit the ADC set up
                            // during the low half.
                            sclk_q  <= 1'b1;
                            shift_q <= {shift_q[FRAME_BITS-2:0], miso};
                        end else if (bit_q == LAST_BIT) begin
                            state_q <= DONE;
                        end else begin
                            sclk_q <= 1'b0;
                            bit_q  <= bit_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    cs_n_q   <= 1'b1;
                    sample_q <= shift_q[ADC_W-1:0];
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // A publish always leaves valid set, even when it coincides with
            // the consumer taking the previous value.
            if (publish) begin
                valid_q <= 1'b1;
            end else if (handshake) begin
                valid_q <= 1'b0;
            end

            // Sticky flags: a set event on the same edge as clr wins.
            overrun_q   <= (overrun_q & ~clr) | (publish & valid_q & ~sample_ready);
            frame_err_q <= (frame_err_q & ~clr) | (publish & lead_nonzero);
        end
    end

    assign cs_n         = cs_n_q;
    assign sclk         = sclk_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign frame_err    = frame_err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pmod_ad_reader.sv
// tb/tb_pmod_ad_reader.sv - directed self-checking bench for pmod_ad_reader

module tb_pmod_ad_reader;

    localparam int CLK_DIV       = 4;
    localparam int SAMPLE_PERIOD = 200;
    localparam int FRAME_LEN     = CLK_DIV + 32 * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic        miso;
    logic        cs_n;
    logic        sclk;
    logic [11:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;
    logic        frame_err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pmod_ad_reader #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clr          (clr),
        .miso         (miso),
        .cs_n         (cs_n),
        .sclk         (sclk),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    // ADC model: presents adc_word MSB first, advancing one bit after each
    // observed SCLK rising edge while cs_n is low.
    logic [15:0] adc_word  = 16'h0000;
    int          bit_idx   = 16;
    logic        prev_cs   = 1'b1;
    logic        prev_sclk = 1'b1;

    always @(negedge clk) begin
        if (prev_cs && !cs_n) begin
            bit_idx = 0;
        end else if (!cs_n && !prev_sclk && sclk) begin
            bit_idx = bit_idx + 1;
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
        miso      = (bit_idx < 16) ? adc_word[15 - bit_idx] : 1'b0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cs_fall(input string tag, input int budget, output int waited);
        logic prev;
        prev   = cs_n;
        waited = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (prev && !cs_n) begin
                waited = i;
                break;
            end
            prev = cs_n;
        end
        check_eq({tag, "_cs_fall_seen"}, 32'(waited > 0), 32'd1);
    endtask

    // Entered on the negedge where cs_n is first seen low; returns on the
    // first negedge with cs_n high again.
    task automatic count_low(output int n);
        n = 0;
        while (cs_n == 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_sclk_rises(input int target, output int rises);
        logic prev;
        prev  = sclk;
        rises = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!prev && sclk) rises++;
            prev = sclk;
            if (rises == target) break;
        end
    endtask

    initial begin
        int w;
        int n;
        int r;
        int seen;
        int falls;
        int first_fall;
        int last_fall;
        int gap_bad;
        logic prev;

        rst          = 1'b1;
        en           = 1'b0;
        clr          = 1'b0;
        sample_ready = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_cs_n", cs_n, 1'b1);
        check_eq("rst_sclk", sclk, 1'b1);
        check_eq("rst_sample", sample, 12'h000);
        check_eq("rst_valid", sample_valid, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);
        check_eq("rst_frame_err", frame_err, 1'b0);
        check_eq("rst_busy", busy, 1'b0);

        // Clean frame, consumer always ready
        do_reset();
        adc_word     = 16'h0A5C;
        sample_ready = 1'b1;
        en           = 1'b1;
        wait_cs_fall("f1", 300, w);
        check_eq("f1_first_fall_time", w, SAMPLE_PERIOD);
        check_eq("f1_busy", busy, 1'b1);
        count_low(n);
        check_eq("f1_cs_low_cycles", n, FRAME_LEN);
        check_eq("f1_sample", sample, 12'hA5C);
        check_eq("f1_valid", sample_valid, 1'b1);
        check_eq("f1_frame_err", frame_err, 1'b0);
        check_eq("f1_busy_after", busy, 1'b0);
        @(negedge clk);
        check_eq("f1_valid_pulse", sample_valid, 1'b0);

        // Nonzero leading bits: published anyway, frame_err sticky until clr
        do_reset();
        adc_word = 16'h8123;
        en       = 1'b1;
        wait_cs_fall("f2", 300, w);
        count_low(n);
        check_eq("f2_sample", sample, 12'h123);
        check_eq("f2_valid", sample_valid, 1'b1);
        check_eq("f2_frame_err", frame_err, 1'b1);
        @(negedge clk);
        check_eq("f2_frame_err_sticky", frame_err, 1'b1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_eq("f2_frame_err_cleared", frame_err, 1'b0);

        // Overrun: consumer stalled across two publishes
        do_reset();
        sample_ready = 1'b0;
        adc_word     = 16'h0111;
        en           = 1'b1;
        wait_cs_fall("f3a", 300, w);
        count_low(n);
        check_eq("f3a_sample", sample, 12'h111);
        check_eq("f3a_valid", sample_valid, 1'b1);
        check_eq("f3a_overrun", overrun, 1'b0);
        adc_word = 16'h0222;
        wait_cs_fall("f3b", 300, w);
        count_low(n);
        check_eq("f3b_sample", sample, 12'h222);
        check_eq("f3b_valid", sample_valid, 1'b1);
        check_eq("f3b_overrun", overrun, 1'b1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_eq("f3b_overrun_cleared", overrun, 1'b0);
        check_eq("f3b_valid_held", sample_valid, 1'b1);

        // Publish coincident with handshake: new value loads, no overrun
        adc_word = 16'h0333;
        wait_cs_fall("f4", 300, w);
        repeat (FRAME_LEN - 1) @(negedge clk);
        sample_ready = 1'b1;
        @(negedge clk);
        check_eq("f4_cs_n_high", cs_n, 1'b1);
        check_eq("f4_sample", sample, 12'h333);
        check_eq("f4_valid", sample_valid, 1'b1);
        check_eq("f4_overrun", overrun, 1'b0);
        @(negedge clk);
        check_eq("f4_valid_dropped", sample_valid, 1'b0);

        // Period: 1000 cycles of en give falls at 200, 400, ..., 1000
        do_reset();
        adc_word   = 16'h0001;
        en         = 1'b1;
        prev       = cs_n;
        falls      = 0;
        first_fall = 0;
        last_fall  = 0;
        gap_bad    = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (prev && !cs_n) begin
                if (falls == 0) first_fall = i;
                else if (i - last_fall != SAMPLE_PERIOD) gap_bad++;
                last_fall = i;
                falls++;
            end
            prev = cs_n;
        end
        check_eq("per_falls", falls, 5);
        check_eq("per_first", first_fall, SAMPLE_PERIOD);
        check_eq("per_gap_errors", gap_bad, 0);

        // Reset mid-frame after the 7th SCLK rise
        do_reset();
        adc_word = 16'h0FFF;
        en       = 1'b1;
        wait_cs_fall("f5", 300, w);
        wait_sclk_rises(7, r);
        check_eq("f5_rises", r, 7);
        check_eq("f5_busy_mid", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("f5_cs_n", cs_n, 1'b1);
        check_eq("f5_sclk", sclk, 1'b1);
        check_eq("f5_busy", busy, 1'b0);
        check_eq("f5_valid", sample_valid, 1'b0);
        rst  = 1'b0;
        en   = 1'b0;
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (sample_valid) seen++;
        end
        check_eq("f5_no_publish", seen, 0);
        check_eq("f5_sample", sample, 12'h000);

        // en dropped mid-frame: frame completes, no new frame starts
        do_reset();
        adc_word = 16'h0444;
        en       = 1'b1;
        wait_cs_fall("f6", 300, w);
        wait_sclk_rises(3, r);
        en = 1'b0;
        count_low(n);
        check_eq("f6_cs_n_high", cs_n, 1'b1);
        check_eq("f6_sample", sample, 12'h444);
        check_eq("f6_valid", sample_valid, 1'b1);
        prev  = cs_n;
        falls = 0;
        repeat (2 * SAMPLE_PERIOD) begin
            @(negedge clk);
            if (prev && !cs_n) falls++;
            prev = cs_n;
        end
        check_eq("f6_no_new_frame", falls, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pmod_ad_reader.md
PMOD_AD_READER -- requirements
Module: pmod_ad_reader

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal range 2..255).
REQ-002 The block SHALL have parameter SAMPLE_PERIOD, default 1000, meaning clk cycles between successive cs_n falling edges (legal range 140..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: enables periodic conversions.
REQ-006 The block SHALL have port clr, input, 1 bit: clears the sticky flags.
REQ-007 The block SHALL have port miso, input, 1 bit: serial data from the ADC PMOD pin.
REQ-008 The block SHALL have port cs_n, output, 1 bit: ADC chip select, active-low.
REQ-009 The block SHALL have port sclk, output, 1 bit: serial clock, idle high.
REQ-010 The block SHALL have port sample, output, 12 bits: last converted value, unsigned.
REQ-011 The block SHALL have port sample_valid, output, 1 bit, and port sample_ready, input, 1 bit: output handshake.
REQ-012 The block SHALL have ports overrun and frame_err, outputs, 1 bit each: sticky error flags.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, SHIFT and DONE.
REQ-015 A free-running period counter SHALL count 0..SAMPLE_PERIOD-1 while en=1 and SHALL hold at 0 while en=0.
REQ-016 IDLE SHALL go to SETUP when the counter equals SAMPLE_PERIOD-1 and en=1; on that edge cs_n SHALL go to 0.
REQ-017 SETUP SHALL last CLK_DIV cycles with cs_n=0 and sclk=1, then go to SHIFT.
REQ-018 SHIFT SHALL produce 16 SCLK periods, each consisting of sclk=0 for CLK_DIV cycles followed by sclk=1 for CLK_DIV cycles.
REQ-019 miso SHALL be captured MSB-first into a 16-bit shift register on the same clk edge that drives sclk from 0 to 1.
REQ-020 After the 16th capture plus its high half-period, the FSM SHALL enter DONE for exactly 1 cycle and then return to IDLE.
REQ-021 On the edge leaving DONE: cs_n SHALL go to 1, sample SHALL load shift[11:0], and sample_valid SHALL go to 1.
REQ-022 Total frame length (cs_n low) SHALL be CLK_DIV + 32*CLK_DIV + 1 cycles, which is 133 cycles at the default.
REQ-023 If any of shift[15:12] is nonzero at publish time, frame_err SHALL be set; the sample SHALL still be published.
REQ-024 sample_valid SHALL stay high and sample SHALL stay stable until a cycle with sample_valid=1 and sample_ready=1.
REQ-025 After the handshake cycle, sample_valid SHALL drop, unless a publish occurs on that same edge.
REQ-026 On a publish while sample_valid=1 and sample_ready=0, the new value SHALL overwrite the old one, sample_valid SHALL remain 1, and overrun SHALL be set.
REQ-027 On a publish coincident with a handshake (valid=1, ready=1), the new value SHALL load, valid SHALL remain 1, and overrun SHALL NOT be set.
REQ-028 Deasserting en mid-frame SHALL let the current frame complete and publish; no new frame SHALL start.
REQ-029 clr=1 SHALL zero overrun and frame_err; if a set event occurs on the same edge, set SHALL win.
REQ-030 busy SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-031 On the clk edge with rst=1, the following SHALL take effect on the next cycle: state=IDLE, cs_n=1, sclk=1, sample=0, sample_valid=0, overrun=0, frame_err=0, busy=0, period counter=0, shift register=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no publish and no flag change other than clearing.

Structure
REQ-033 Shared package pmod_pkg SHALL hold the state enum, FRAME_BITS=16, LEAD_ZEROS=4 and ADC_W=12.
REQ-034 SCLK phase generation (half-period counter plus edge strobe) SHALL be a sub-module named sclk_divider; the FSM, shifter and handshake SHALL live in pmod_ad_reader.

Verification
REQ-035 ADC model returns 16'h0A5C, en=1, ready=1 -> sample=12'hA5C, valid pulses 1 cycle, frame_err=0, and cs_n is low for 133 cycles.
REQ-036 ADC model returns 16'h8123 -> sample=12'h123, frame_err=1; then clr=1 for 1 cycle -> frame_err=0.
REQ-037 ready=0, two frames returning 16'h0111 then 16'h0222 -> sample=12'h222, valid=1, overrun=1.
REQ-038 SAMPLE_PERIOD=200, en=1 for 1000 cycles -> cs_n falling edges exactly 200 cycles apart, 5 frames total.
REQ-039 rst=1 asserted after the 7th sclk rising edge -> next cycle cs_n=1, sclk=1, busy=0, valid stays 0, and no sample is published.
REQ-040 en dropped at the 3rd sclk rising edge -> frame completes and publishes; no further cs_n falling edge occurs for 2*SAMPLE_PERIOD cycles.
